// File: rtl/ann_pkg.sv
// Shared types and constants for the fully-connected layer scheduler.
//   FP_ONE / FP_ZERO : IEEE-754 single-precision constants (bias operand, clamp value)
//   state_t          : scheduler FSM states
//   cw/addr_w/term_w/nrn_w : clog2-based counter widths, never narrower than 1 bit
package ann_pkg;

  localparam logic [31:0] FP_ONE  = 32'h3F80_0000;
  localparam logic [31:0] FP_ZERO = 32'h0000_0000;

  typedef enum logic [2:0] {IDLE, LOAD, CLR, FEED, DRAIN, OUT} state_t;

  function automatic int cw(input int v);
    return (v > 1) ? $clog2(v) : 1;
  endfunction

  // weight-memory address: M rows of N weights + 1 bias
  function automatic int addr_w(input int n, input int m);
    return cw(m * (n + 1));
  endfunction

  // term index 0..N (N = bias term)
  function automatic int term_w(input int n);
    return cw(n + 1);
  endfunction

  // neuron index 0..M-1
  function automatic int nrn_w(input int m);
    return cw(m);
  endfunction

endpackage

// File: rtl/layer_scheduler_if.sv
// Bus bundle for layer_scheduler.
//   x_*   : input-vector stream (valid/ready)
//   w_*   : weight-memory read port (data one cycle after address)
//   mac_* : shared FP multiply-accumulate unit control/operands/result
//   y_*   : neuron result stream (valid/ready), layer_done pulse
// Modports: master = scheduler side, slave = environment side.
interface layer_scheduler_if #(
  parameter int N  = 3,
  parameter int M  = 4,
  parameter int DW = 32
);
  import ann_pkg::*;

  localparam int AW = addr_w(N, M);
  localparam int IW = nrn_w(M);

  logic [DW-1:0] x_data;
  logic          x_valid;
  logic          x_ready;
  logic [AW-1:0] w_addr;
  logic [DW-1:0] w_data;
  logic          mac_clr;
  logic          mac_en;
  logic [DW-1:0] mac_w;
  logic [DW-1:0] mac_x;
  logic [DW-1:0] mac_acc;
  logic [DW-1:0] y_data;
  logic [IW-1:0] y_idx;
  logic          y_valid;
  logic          y_ready;
  logic          layer_done;

  modport master (
    input  x_data, x_valid, w_data, mac_acc, y_ready,
    output x_ready, w_addr, mac_clr, mac_en, mac_w, mac_x,
           y_data, y_idx, y_valid, layer_done
  );

  modport slave (
    output x_data, x_valid, w_data, mac_acc, y_ready,
    input  x_ready, w_addr, mac_clr, mac_en, mac_w, mac_x,
           y_data, y_idx, y_valid, layer_done
  );

endinterface

// File: rtl/layer_scheduler_relu_clamp.sv
// relu_clamp: combinational bit-level ReLU. Any value with the sign bit set
// (negative numbers and -0.0) becomes +0.0; everything else passes through.
//   din  : accumulator value
//   dout : clamped value
module relu_clamp
  import ann_pkg::*;
#(
  parameter int DW = 32
) (
  input  logic [DW-1:0] din,
  output logic [DW-1:0] dout
);

  assign dout = din[DW-1] ? DW'(FP_ZERO) : din;

endmodule

// File: rtl/layer_scheduler.sv
// layer_scheduler: runs one fully-connected layer of M neurons x N inputs
// through a single external FP MAC. Buffers the input vector, then per neuron
// clears the MAC, streams N weights plus the bias (against x = 1.0), waits out
// the MAC latency, and presents the result on the y stream.
//   clk, rst : clock, synchronous active-high reset
//   bus      : layer_scheduler_if.master (x stream, weight port, MAC, y stream)
// Optional: define LAYER_SCHED_RELU_EN to clamp negative results (incl. -0.0)
// to +0.0; otherwise y_data is the raw latched accumulator.
module layer_scheduler
  import ann_pkg::*;
#(
  parameter int N       = 3,
  parameter int M       = 4,
  parameter int MAC_LAT = 2,
  parameter int DW      = 32
) (
  input  logic               clk,
  input  logic               rst,
  layer_scheduler_if.master  bus
);

  localparam int AW = addr_w(N, M);
  localparam int TW = term_w(N);
  localparam int JW = nrn_w(M);

  state_t state, state_n;

  logic [TW-1:0]      k;          // input-vector load index
  logic [TW-1:0]      t;          // term index within a neuron
  logic [JW-1:0]      j;          // neuron index
  logic [AW-1:0]      base;       // j*(N+1), kept incrementally
  logic [DW-1:0]      xbuf  [N];
  logic [DW-1:0]      terms [N+1];
  logic [DW-1:0]      acc_q;
  logic [DW-1:0]      y_f;
  logic [MAC_LAT-1:0] vld_pipe;   // tracks the last beat through the MAC latency

  logic last_x, last_term, last_nrn, last_beat;

  assign last_x    = (k == TW'(N - 1));
  assign last_term = (t == TW'(N));
  assign last_nrn  = (j == JW'(M - 1));
  assign last_beat = (state == FEED) && last_term;

  // operand x for each term; the bias term multiplies against 1.0
  for (genvar i = 0; i < N; i++) begin : g_terms
    assign terms[i] = xbuf[i];
  end
  assign terms[N] = DW'(FP_ONE);

`ifdef LAYER_SCHED_RELU_EN
  relu_clamp #(.DW(DW)) u_relu (.din(acc_q), .dout(y_f));
`else
  assign y_f = acc_q;
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      k        <= '0;
      t        <= '0;
      j        <= '0;
      base     <= '0;
      acc_q    <= '0;
      vld_pipe <= '0;
      for (int i = 0; i < N; i++) xbuf[i] <= '0;
    end else begin
      // bit MAC_LAT-1 is set exactly MAC_LAT cycles after the last mac_en beat
      vld_pipe <= (vld_pipe << 1) | MAC_LAT'(last_beat);
      case (state)
        LOAD: if (bus.x_valid) begin
          xbuf[k] <= bus.x_data;
          k       <= last_x ? '0 : k + 1'b1;
          j       <= '0;
          base    <= '0;
        end
        CLR:   t <= '0;
        FEED:  t <= t + 1'b1;
        DRAIN: if (vld_pipe[MAC_LAT-1]) acc_q <= bus.mac_acc;
        OUT: if (bus.y_ready) begin
          j    <= last_nrn ? '0 : j + 1'b1;
          base <= last_nrn ? '0 : base + AW'(N + 1);
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_n        = state;
    bus.x_ready    = 1'b0;
    bus.w_addr     = '0;
    bus.mac_clr    = 1'b0;
    bus.mac_en     = 1'b0;
    bus.mac_w      = '0;
    bus.mac_x      = '0;
    bus.y_data     = '0;
    bus.y_idx      = '0;
    bus.y_valid    = 1'b0;
    bus.layer_done = 1'b0;
    case (state)
      IDLE: state_n = LOAD;
      LOAD: begin
        bus.x_ready = 1'b1;
        if (bus.x_valid && last_x) state_n = CLR;
      end
      CLR: begin
        bus.mac_clr = 1'b1;
        bus.w_addr  = base;
        state_n     = FEED;
      end
      FEED: begin
        // w_data holds term t (addressed last cycle); prefetch term t+1
        bus.mac_en = 1'b1;
        bus.mac_w  = bus.w_data;
        bus.mac_x  = terms[t];
        bus.w_addr = last_term ? '0 : base + AW'(t) + AW'(1);
        if (last_term) state_n = DRAIN;
      end
      DRAIN: if (vld_pipe[MAC_LAT-1]) state_n = OUT;
      OUT: begin
        bus.y_valid = 1'b1;
        bus.y_idx   = j;
        bus.y_data  = y_f;
        if (bus.y_ready) begin
          bus.layer_done = last_nrn;
          state_n        = last_nrn ? IDLE : CLR;
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_layer_scheduler.sv
// Self-checking bench for layer_scheduler (N=3, M=4, MAC_LAT=2) with a
// behavioural FP MAC and a 1-cycle weight ROM. Expected results are
// hand-computed float32 constants held in a vector table.
module tb_layer_scheduler;
  import ann_pkg::*;

  localparam int N = 3, M = 4, LAT = 2;

  localparam logic [31:0] F0 = 32'h0000_0000, F1 = 32'h3F80_0000;
  localparam logic [31:0] F2 = 32'h4000_0000, F3 = 32'h4040_0000;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  layer_scheduler_if #(.N(N), .M(M), .DW(32)) bus ();

  layer_scheduler #(.N(N), .M(M), .MAC_LAT(LAT), .DW(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // ---------------- float helpers for the MAC model ----------------
  function automatic real f2r(input logic [31:0] b);
    real m;
    int  e;
    if (b[30:23] == 8'd0) return 0.0;
    e = int'(b[30:23]) - 127;
    m = (1.0 + real'(int'(b[22:0])) / 8388608.0) * (2.0 ** e);
    return b[31] ? -m : m;
  endfunction

  function automatic logic [31:0] r2f(input real r);
    real  a;
    int   e, mt;
    logic s;
    if (r == 0.0) return 32'h0;
    s = (r < 0.0);
    a = s ? -r : r;
    e = 0;
    while (a >= 2.0) begin a = a / 2.0; e++; end
    while (a < 1.0)  begin a = a * 2.0; e--; end
    mt = $rtoi((a - 1.0) * 8388608.0 + 0.5);
    if (mt == 8388608) begin mt = 0; e++; end
    return {s, 8'(e + 127), mt[22:0]};
  endfunction

  // ---------------- behavioural MAC (latency 2) and weight ROM -------------
  real  acc_r  = 0.0;
  real  prod_q = 0.0;
  logic prod_v = 1'b0;
  always @(posedge clk) begin
    if (bus.mac_clr)  acc_r <= 0.0;
    else if (prod_v)  acc_r <= acc_r + prod_q;
    prod_v <= bus.mac_en;
    prod_q <= f2r(bus.mac_w) * f2r(bus.mac_x);
  end
  always_comb bus.mac_acc = r2f(acc_r);

  logic [31:0] rom [16];
  always @(posedge clk) bus.w_data <= rom[bus.w_addr];

  // ---------------- activity monitor ----------------
  int en_cnt = 0, clr_cnt = 0, done_cnt = 0, ovl_cnt = 0;
  always @(posedge clk) begin
    if (bus.mac_en)                 en_cnt   <= en_cnt + 1;
    if (bus.mac_clr)                clr_cnt  <= clr_cnt + 1;
    if (bus.layer_done)             done_cnt <= done_cnt + 1;
    if (bus.mac_en && bus.mac_clr)  ovl_cnt  <= ovl_cnt + 1;
  end

  // ---------------- checking ----------------
  int n_chk = 0, n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp, input bit tol);
    bit ok;
    n_chk++;
    ok = (act == exp) || (tol && (act == exp + 32'd1 || act == exp - 32'd1));
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h%s", nm, act, exp, tol ? " (+-1 ulp)" : "");
    end
  endtask

  task automatic timeout(input string nm);
    n_chk++;
    n_fail++;
    $display("FAIL %s: timed out", nm);
  endtask

  function automatic logic [31:0] clamp(input logic [31:0] v);
`ifdef LAYER_SCHED_RELU_EN
    return v[31] ? 32'h0 : v;
`else
    return v;
`endif
  endfunction

  function automatic logic [31:0] out_or();
    return bus.y_data | bus.mac_w | bus.mac_x |
           32'({bus.x_ready, bus.y_valid, bus.mac_clr, bus.mac_en,
                bus.layer_done, bus.y_idx, bus.w_addr});
  endfunction

  // ---------------- vector table ----------------
  typedef struct {
    logic [31:0] x [3];
    logic [31:0] y [4];   // raw (unclamped) neuron results
    bit   [3:0]  tol;     // per-neuron +-1 ulp allowance
  } vec_t;
  vec_t tbl [4];

  task automatic load_vec(input int v, input bit rnd);
    int k = 0;
    int cyc = 0;
    while (k < 3 && cyc < 200) begin
      @(negedge clk);
      cyc++;
      bus.x_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      bus.x_data  = bus.x_valid ? tbl[v].x[k] : 32'hBAD0_0000 | 32'(cyc);
      if (bus.x_valid && bus.x_ready) k++;
    end
    if (k < 3) timeout($sformatf("load L%0d", v));
    @(negedge clk);
    bus.x_valid = 1'b0;
    bus.x_data  = 32'hDEAD_BEEF;
  endtask

  task automatic get_res(input int v, input int n, input int stall, input bit offer);
    int cyc = 0;
    logic [31:0] d0;
    logic [1:0]  i0;
    while (!bus.y_valid && cyc < 200) begin @(negedge clk); cyc++; end
    if (!bus.y_valid) begin timeout($sformatf("result L%0d n%0d", v, n)); return; end
    chk($sformatf("y_idx L%0d n%0d", v, n), 32'(bus.y_idx), 32'(n), 1'b0);
    chk($sformatf("y_data L%0d n%0d", v, n), bus.y_data, clamp(tbl[v].y[n]), tbl[v].tol[n]);
    d0 = bus.y_data;
    i0 = bus.y_idx;
    for (int s = 0; s < stall; s++) begin
      @(negedge clk);
      chk($sformatf("stall data c%0d", s), bus.y_data, d0, 1'b0);
      chk($sformatf("stall ctl c%0d", s), {28'b0, bus.y_valid, bus.mac_en, bus.y_idx},
          {28'b0, 1'b1, 1'b0, i0}, 1'b0);
    end
    if (offer) begin
      bus.x_valid = 1'b1;
      bus.x_data  = tbl[v + 1].x[0];
      #1 chk("x_ready in OUT", 32'(bus.x_ready), 32'd0, 1'b0);
    end
    bus.y_ready = 1'b1;
    #1 chk($sformatf("layer_done L%0d n%0d", v, n), 32'(bus.layer_done), 32'(n == M - 1), 1'b0);
    @(negedge clk);
    bus.y_ready = 1'b0;
    if (offer) begin
      chk("x_ready after done+1", 32'(bus.x_ready), 32'd0, 1'b0);
      @(negedge clk);
      chk("x_ready after done+2", 32'(bus.x_ready), 32'd1, 1'b0);
      bus.x_valid = 1'b0;
    end
  endtask

  task automatic run_layer(input int v);
    int e0, c0, d0;
    e0 = en_cnt;
    c0 = clr_cnt;
    d0 = done_cnt;
    load_vec(v, v == 0);
    for (int n = 0; n < M; n++)
      get_res(v, n, (v == 0 && n == 1) ? 10 : 0, (v == 1 && n == M - 1));
    chk($sformatf("mac_en beats L%0d", v), 32'(en_cnt - e0), 32'(M * (N + 1)), 1'b0);
    chk($sformatf("mac_clr pulses L%0d", v), 32'(clr_cnt - c0), 32'(M), 1'b0);
    chk($sformatf("layer_done pulses L%0d", v), 32'(done_cnt - d0), 32'd1, 1'b0);
  endtask

  initial begin
    int c0, d0, cyc;

    rom = '{32'h3F33_3333, 32'h3E99_999A, 32'h3E4C_CCCD, 32'h3E4C_CCCD,  // 0.7 0.3 0.2 | 0.2
            32'hBF80_0000, 32'hBF80_0000, 32'hBF80_0000, 32'h0000_0000,  // -1 -1 -1 | 0
            32'h3F00_0000, 32'h3E80_0000, 32'h4000_0000, 32'hBF80_0000,  // 0.5 0.25 2 | -1
            32'h3F80_0000, 32'h3F80_0000, 32'h3F80_0000, 32'h4120_0000}; // 1 1 1 | 10

    tbl[0].x = '{F1, F2, F3};
    tbl[0].y = '{32'h4006_6666, 32'hC0C0_0000, 32'h40C0_0000, 32'h4180_0000}; // 2.1 -6 6 16
    tbl[0].tol = 4'b0001;
    tbl[1].x = '{F1, F1, F1};
    tbl[1].y = '{32'h3FB3_3333, 32'hC040_0000, 32'h3FE0_0000, 32'h4150_0000}; // 1.4 -3 1.75 13
    tbl[1].tol = 4'b0001;
    tbl[2].x = '{F2, F0, F1};
    tbl[2].y = '{32'h3FE6_6666, 32'hC040_0000, 32'h4000_0000, 32'h4150_0000}; // 1.8 -3 2 13
    tbl[2].tol = 4'b0001;
    tbl[3] = tbl[1];

    rst         = 1'b1;
    bus.x_valid = 1'b0;
    bus.x_data  = '0;
    bus.y_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset outputs", out_or(), 32'd0, 1'b0);
    rst = 1'b0;
    @(negedge clk);
    chk("x_ready after reset", 32'(bus.x_ready), 32'd1, 1'b0);

    for (int v = 0; v < 3; v++) run_layer(v);

    // abort a layer during FEED of neuron 2
    c0 = clr_cnt;
    bus.y_ready = 1'b1;
    load_vec(0, 1'b0);
    cyc = 0;
    while (clr_cnt < c0 + 3 && cyc < 300) begin @(negedge clk); cyc++; end
    if (clr_cnt < c0 + 3) timeout("reach neuron 2");
    @(negedge clk);
    chk("mac_en before abort", 32'(bus.mac_en), 32'd1, 1'b0);
    d0  = done_cnt;
    rst = 1'b1;
    @(negedge clk);
    chk("outputs after abort", out_or(), 32'd0, 1'b0);
    rst = 1'b0;
    bus.y_ready = 1'b0;
    @(negedge clk);
    chk("x_ready after abort", 32'(bus.x_ready), 32'd1, 1'b0);
    chk("no layer_done on abort", 32'(done_cnt - d0), 32'd0, 1'b0);

    run_layer(3);

    chk("mac_en with mac_clr", 32'(ovl_cnt), 32'd0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/layer_scheduler.md
Name: layer_scheduler

Overview:
- Sequences one fully-connected layer of M neurons, each with N inputs, through a single shared floating-point multiply-accumulate unit (MAC).
- Buffers one input vector, then for each neuron:
  - fetches the N weights plus the bias from an external weight memory;
  - feeds them to the MAC;
  - waits out the MAC latency;
  - emits the ReLU-clamped result on a valid/ready stream.
- Sits between the input-vector stream and the next layer; replaces the one-neuron-per-MAC arrangement.

Parameters:
- N, 3: inputs per neuron (>=1).
- M, 4: neurons in the layer (>=1).
- MAC_LAT, 2: cycles from a mac_en beat until its contribution is visible on mac_acc (>=1).
- DW, 32: data width, IEEE-754 single precision.

Ports:
- clk, input, 1: clock.
- rst, input, 1: reset. Synchronous, active-high.
- x_data, input, DW: input-vector element.
- x_valid, input, 1: x_data valid.
- x_ready, output, 1: scheduler accepts x_data.
- w_addr, output, clog2(M*(N+1)): weight-memory read address.
- w_data, input, DW: weight-memory read data, valid one cycle after w_addr.
- mac_clr, output, 1: synchronous clear of the MAC accumulator.
- mac_en, output, 1: accumulate mac_w*mac_x this cycle.
- mac_w, output, DW: MAC weight operand.
- mac_x, output, DW: MAC data operand.
- mac_acc, input, DW: MAC accumulator value.
- y_data, output, DW: neuron result.
- y_idx, output, clog2(M): index of the neuron producing y_data.
- y_valid, output, 1: result valid.
- y_ready, input, 1: downstream accepts the result.
- layer_done, output, 1: one-cycle pulse when the last neuron's result is accepted.

Behaviour:
- Reset values: x_ready=0, y_valid=0, y_data=0, y_idx=0, mac_clr=0, mac_en=0, mac_w=0, mac_x=0, w_addr=0, layer_done=0. State=IDLE. Counters cleared.
- Reset mid-operation aborts the layer immediately and discards all buffered inputs. No layer_done is produced.

State machine:
- IDLE: go to LOAD the next cycle.
- LOAD:
  - x_ready=1.
  - Each x_valid&&x_ready beat stores x_data into xbuf[k], k=0..N-1.
  - After the N-th beat: j=0, go to CLR.
- CLR:
  - mac_clr=1 for one cycle.
  - Issue w_addr = j*(N+1)+0.
  - Go to FEED.
- FEED, term index t=0..N:
  - Each cycle issues w_addr for term t+1 while the MAC consumes term t.
  - mac_en=1; mac_w=w_data; mac_x=xbuf[t] for t<N.
  - For t=N the term is the bias: mac_x = 1.0 (32'h3F800000), weight at address j*(N+1)+N.
  - Exactly N+1 mac_en beats per neuron; mac_en is never asserted in the same cycle as mac_clr.
- DRAIN: wait MAC_LAT cycles after the last mac_en beat, then latch the result.
- OUT:
  - y_valid=1, y_idx=j, y_data=f(mac_acc latched at DRAIN exit).
  - y_data, y_idx and y_valid stay stable until y_ready.
  - On handshake with j<M-1: j++, go to CLR.
  - On handshake with j=M-1: layer_done=1 that cycle, go to IDLE.
  - x_ready therefore rises two cycles after layer_done.

Handshake and boundary rules:
- x_ready=0 outside LOAD; x_valid is ignored there.
- y_ready held low stalls the scheduler indefinitely in OUT, with no MAC activity.
- N=1 and M=1 are legal: N=1 gives two FEED beats; M=1 gives layer_done on the first handshake.

Arithmetic:
- The scheduler performs no FP arithmetic except the output clamp f.
- The clamp is bit-level: if the sign bit is set (including -0.0), the output is 32'h00000000.

Optional Feature:
- Macro: LAYER_SCHED_RELU_EN.
- Defined: f applies the ReLU clamp above.
- Undefined: f is identity; y_data = latched mac_acc, unmodified, including negative values and -0.0.

Decomposition:
- Package ann_pkg holds:
  - FP_ONE=32'h3F800000 and FP_ZERO=32'h00000000;
  - the state enum {IDLE, LOAD, CLR, FEED, DRAIN, OUT};
  - clog2-based width constants for the address, term and neuron counters.
- One natural sub-module, relu_clamp: combinational sign-bit clamp, instantiated only under LAYER_SCHED_RELU_EN.
- The MAC and weight memory stay external.

Test Plan:
All scenarios use a behavioural FP MAC model with MAC_LAT=2 and a 1-cycle-latency weight ROM.
- Basic: N=3, M=1, W={0.7,0.3,0.2}, bias 0.2, x={1.0,2.0,3.0} -> y_data≈2.1 (32'h40066666, ±1 ulp), y_idx=0, layer_done pulse on handshake.
- ReLU: W={-1.0,-1.0,-1.0}, bias 0.0, x={1.0,1.0,1.0} -> y_data=32'h00000000 with LAYER_SCHED_RELU_EN; 32'hC0400000 without.
- Multi-neuron: M=4, distinct weight rows -> four results with y_idx 0,1,2,3 in order, each matching a reference model; exactly 4*(N+1) mac_en beats and 4 mac_clr pulses.
- Backpressure:
  - y_ready low for 10 cycles in OUT -> y_data, y_idx, y_valid stable and mac_en=0 throughout.
  - x_valid toggling randomly in LOAD -> only handshaked beats stored.
- Reset mid-FEED of neuron 2 -> all outputs at reset values next cycle, x_ready=1 one cycle later. A fresh vector then yields correct results starting at y_idx=0.
- Back-to-back layers: new vector offered during OUT of the last neuron -> not accepted until x_ready rises two cycles after layer_done; second layer results are correct.
